array_output_aligner: RTL

- Sits directly downstream of the systolic processing array and consumes its per-column down-border result streams.
- Array columns emit results skewed in time. This block buffers each column in its own lane FIFO.
- Once every lane holds a head beat, it emits them together as one wide, column-aligned AXI-Stream beat.
- It also checks that tlast is consistent across columns and resynchronises the lanes when it is not.

---
 rtl/array_output_aligner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/array_output_aligner.sv
// Aligns per-column skewed result streams from the systolic array into one wide beat.
// Each column is buffered in a lane FIFO; mixed tlast heads are discarded up to the next tlast per lane.
module array_output_aligner #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LANES-1:0]            s_axis_tvalid,
  output logic [LANES-1:0]            s_axis_tready,
  input  logic [LANES-1:0]            s_axis_tlast,
  input  logic [LANES*USER_WIDTH-1:0] s_axis_tuser,
  output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [LANES*USER_WIDTH-1:0] m_axis_tuser,
  output logic                        err_unaligned_data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + USER_WIDTH + 1;

  // state | meaning
  // RUN   | pop all lanes together when every lane has a head and the output can load
  // DROP  | discard beats on each not-done lane up to and including its tlast
  typedef enum logic {RUN, DROP} state_t;

  state_t                      state, state_nxt;
  logic                        ready_en;
  logic [LANES-1:0]            full, empty, push, pop, head_last, done, done_nxt;
  logic [LANES*DATA_WIDTH-1:0] head_data;
  logic [LANES*USER_WIDTH-1:0] head_user;
  logic                        load_ok, all_same, emit, err_set;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
        if (pop[k])  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end

    // storage needs no reset: pointers alone define validity
    always_ff @(posedge clk) begin
      if (push[k])
        mem[wr_ptr[AW-1:0]] <= {s_axis_tlast[k],
                                s_axis_tuser[k*USER_WIDTH +: USER_WIDTH],
                                s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH]};
    end

    assign empty[k] = (wr_ptr == rd_ptr);
    assign full[k]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push[k]  = s_axis_tvalid[k] & s_axis_tready[k];
    assign {head_last[k],
            head_user[k*USER_WIDTH +: USER_WIDTH],
            head_data[k*DATA_WIDTH +: DATA_WIDTH]} = mem[rd_ptr[AW-1:0]];
  end

  // holds tready low through reset and releases it on the first edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign s_axis_tready = ready_en ? ~full : '0;
  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign all_same      = (&head_last) || !(|head_last);

  always_comb begin
    state_nxt = state;
    pop       = '0;
    done_nxt  = done;
    emit      = 1'b0;
    err_set   = 1'b0;
    case (state)
      RUN: begin
        if (!(|empty) && load_ok) begin
          pop = '1;
          if (all_same) begin
            emit = 1'b1;
          end else begin
            err_set   = 1'b1;
            done_nxt  = head_last;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        pop      = ~done & ~empty;
        done_nxt = done | (pop & head_last);
        if (&done_nxt) begin
          done_nxt  = '0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      done  <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tdata       <= '0;
      m_axis_tuser       <= '0;
      err_unaligned_data <= 1'b0;
    end else begin
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= head_last[0];
        m_axis_tdata  <= head_data;
        m_axis_tuser  <= head_user;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      err_unaligned_data <= err_set;
    end
  end

endmodule
